// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing for the SRAM arbiter/sequencer.
// The sequencer FSM walks IDLE -> SETUP -> ACCESS -> RELEASE for every access.
package sram_ctrl_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. On a tie the master not granted last time wins.
// The last-grant register only moves when the caller accepts a grant via advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_id,
  output logic       any_req
);

  logic last_q;
  logic last_d;

  assign any_req = |req;

  always_comb begin
    if (req == 2'b11) grant_id = ~last_q;
    else              grant_id = req[1];
  end

  assign last_d = advance ? grant_id : last_q;

  // Reset to 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Arbitrates two masters onto one asynchronous SRAM and sequences each access
// so that address and RWS only move while CS is low.
module sram_arb_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int ACC_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic          sram_cs,
  output logic          sram_rws,
  output logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_io
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_CYC - 1);

  state_e               state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic                 owner_q,  owner_d;
  logic                 cs_q,     cs_d;
  logic                 rws_q,    rws_d;
  logic [AW-1:0]        addr_q,   addr_d;
  logic [DW-1:0]        wdata_q,  wdata_d;
  logic [1:0]           gnt_q,    gnt_d;
  logic [1:0]           done_q,   done_d;
  logic [1:0][DW-1:0]   rdata_q,  rdata_d;

  logic advance;
  logic grant_id;
  logic any_req;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({m1_req, m0_req}),
    .advance  (advance),
    .grant_id (grant_id),
    .any_req  (any_req)
  );

  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    cs_d    = cs_q;
    rws_d   = rws_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_d   = '0;
    done_d  = '0;
    rdata_d = rdata_q;
    advance = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          advance         = 1'b1;
          owner_d         = grant_id;
          rws_d           = grant_id ? m1_we    : m0_we;
          addr_d          = grant_id ? m1_addr  : m0_addr;
          wdata_d         = grant_id ? m1_wdata : m0_wdata;
          gnt_d[grant_id] = 1'b1;
          state_d         = SETUP;
        end
      end
      SETUP: begin
        cs_d    = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          cs_d            = 1'b0;
          done_d[owner_q] = 1'b1;
          if (!rws_q) rdata_d[owner_q] = sram_io;
          state_d         = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        rws_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      cs_q    <= 1'b0;
      rws_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      cs_q    <= cs_d;
      rws_q   <= rws_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // RWS doubles as the bus drive enable, so the controller can never fight
  // the SRAM's own read driver.
  assign sram_io   = rws_q ? wdata_q : {DW{1'bz}};
  assign sram_cs   = cs_q;
  assign sram_rws  = rws_q;
  assign sram_addr = addr_q;
  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_done   = done_q[0];
  assign m1_done   = done_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
Two-port round-robin arbiter and access sequencer for the 1024x8 asynchronous SRAM. It has a single shared tristate IO bus and CS/RWS/addr pins. It accepts read/write requests from two masters and serialises them onto the SRAM pins with a setup/access/release sequence. This guarantees addr/RWS change only while CS=0 and prevents bus contention. It returns read data and a completion pulse to the owning master.

Parameters:
AW, 10, SRAM address width
DW, 8, SRAM data width
ACC_CYC, 2, cycles CS is held asserted per access (legal range 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, synchronous, active-low
m0_req  input  1  master 0 request, held until m0_gnt
m0_we  input  1  master 0 op: 1=write, 0=read
m0_addr  input  AW  master 0 address
m0_wdata  input  DW  master 0 write data
m0_gnt  output  1  one-cycle pulse: request latched
m0_done  output  1  one-cycle pulse: access complete
m0_rdata  output  DW  read data, valid with m0_done on reads, held until next m0 read
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata  same as master 0
sram_cs  output  1  SRAM chip select, active-high
sram_rws  output  1  SRAM read/write select: 0=read, 1=write
sram_addr  output  AW  SRAM address
sram_io  inout  DW  SRAM data bus, driven only for writes, else Z

Behaviour:
- One clock domain. Reset is synchronous and active-low; the clock port is clk and the reset port is rst_n.
- Reset values, applied at the first edge with rst_n=0:
  - state=IDLE; sram_cs=0, sram_rws=0, sram_addr=0, sram_io=Z.
  - gnt/done=0; rdata=0; RR pointer last=1, so m0 wins first.
- All outputs are registered except sram_io, which is the tristate of a registered data/enable.
- FSM states:
  - IDLE: if any req is high, pick a winner, latch its we/addr/wdata and the owner id, and go to SETUP. Otherwise stay.
  - SETUP (1 cycle): gnt[owner]=1. sram_addr and sram_rws take the latched values and cs=0. On a write, sram_io drives wdata from this cycle. Go to ACCESS with cnt=0.
  - ACCESS (ACC_CYC cycles): cs=1; addr, rws and io held. On reads, capture sram_io into rdata[owner] at the edge ending the last ACCESS cycle. Go to RELEASE when cnt==ACC_CYC-1.
  - RELEASE (1 cycle): cs=0; addr, rws and io still held (write hold time). done[owner]=1. Go to IDLE.
  - Leaving RELEASE: io returns to Z and rws returns to 0.
- Timing:
  - Request sampled in IDLE at edge k.
  - gnt is high in cycle k+1.
  - done is high in cycle k+2+ACC_CYC.
  - Back-to-back period with req held is 3+ACC_CYC cycles.
- Arbitration:
  - Single requester wins.
  - When both request, the master not granted last wins, and last is updated to the winner.
  - Requests are evaluated only in IDLE. A req still high in the IDLE after gnt counts as a new request.
- Invariants:
  - sram_rws and sram_addr never change while sram_cs=1.
  - Controller drives sram_io only when rws=1, so there is no contention with the SRAM read driver (CS&~RWS).
  - Request inputs are ignored outside IDLE.
- Reset mid-operation returns to IDLE at that edge: cs=0, io=Z, no done pulse for the aborted access, RR pointer reset.
- Addresses cover the full 0..2^AW-1 range with no wrap or translation.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum IDLE/SETUP/ACCESS/RELEASE (2-bit);
  - default AW/DW;
  - ACC_CYC counter width (4 bits).
- Sub-module rr_arb2 holds:
  - inputs req[1:0], advance;
  - outputs grant_id, any_req;
  - the internal last-grant register, reset to 1.
- The top level keeps the FSM, request latch and pin drivers.

Test Plan:
1. After reset, m0 writes addr=0x3FF, data=0xA5 (ACC_CYC=2):
   - m0_gnt in cycle +1;
   - sram_cs=1 for exactly 2 cycles with rws=1, addr=0x3FF;
   - sram_io=0xA5 from SETUP through RELEASE;
   - m0_done in cycle +4; io Z afterwards.
2. m1 reads addr=0x3FF:
   - m1_rdata=0xA5 with m1_done;
   - controller never drives sram_io;
   - m0_rdata unchanged.
3. m0 and m1 request simultaneously, three times (each re-request only after its previous gnt):
   - grant order m0, m1, m0;
   - no overlap of cs windows.
4. Write 0x3C to 0x000 and 0xC3 to 0x3FF, then read both:
   - rdata 0x3C and 0xC3 respectively (address boundaries).
5. Assert rst_n=0 during the second ACCESS cycle of a write:
   - next edge cs=0, io=Z, no done;
   - a subsequent m1 read completes normally and m0 wins the next tie.
6. m0 holds req high continuously for 4 reads, m1 idle:
   - m0_gnt pulses every 5 cycles (3+ACC_CYC);
   - sram_rws stays 0 throughout.
